accumulator_unit: RTL

ACCUMULATOR_UNIT -- requirements
Module: accumulator_unit

---
 rtl/accumulator_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/accumulator_unit.sv
// Accumulator datapath controller: sequences load/store/add/subtract through an
// external memory port and an external combinational ALU.
module accumulator_unit (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        start_in,
  input  logic [2:0]  opcode_in,
  input  logic [10:0] operand_in,
  input  logic [10:0] mem_data_in,
  input  logic        mem_ready_in,
  output logic [10:0] mem_addr_out,
  output logic [10:0] mem_data_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [10:0] A_out,
  output logic [10:0] B_out,
  output logic        operation_out,
  input  logic [10:0] alu_in,
  output logic [10:0] acc_out,
  output logic        zero_out,
  output logic        neg_out,
  output logic        busy_out,
  output logic        done_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LD   = 3'b001,
    OP_LDI  = 3'b010,
    OP_STO  = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101,
    OP_ADDI = 3'b110,
    OP_SUBI = 3'b111
  } opcode_t;

  state_t      state_q,   state_d;
  opcode_t     opcode_q,  opcode_d;
  logic [10:0] operand_q, operand_d;
  logic [10:0] acc_q,     acc_d;
  logic [10:0] b_q,       b_d;
  logic        op_sub_q,  op_sub_d;

  opcode_t     opcode_new;
  logic        in_mem;

  assign opcode_new = opcode_t'(opcode_in);

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    b_d       = b_q;
    op_sub_d  = op_sub_q;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          opcode_d  = opcode_new;
          operand_d = operand_in;
          op_sub_d  = (opcode_new == OP_SUB) || (opcode_new == OP_SUBI);
          case (opcode_new)
            OP_NOP:                   state_d = DONE;
            OP_LDI, OP_ADDI, OP_SUBI: begin
              b_d     = operand_in;
              state_d = EXEC;
            end
            default:                  state_d = MEM;
          endcase
        end
      end
      MEM: begin
        if (mem_ready_in) begin
          if (opcode_q == OP_STO) begin
            state_d = DONE;
          end else begin
            b_d     = mem_data_in;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        // Only LD/LDI and the four arithmetic ops ever reach EXEC.
        if ((opcode_q == OP_LD) || (opcode_q == OP_LDI)) begin
          acc_d = b_q;
        end else begin
          acc_d = alu_in;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      opcode_q  <= OP_NOP;
      operand_q <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      op_sub_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      op_sub_q  <= op_sub_d;
    end
  end

  assign in_mem        = (state_q == MEM);
  assign mem_addr_out  = operand_q;
  assign mem_data_out  = acc_q;
  assign mem_write_out = in_mem && (opcode_q == OP_STO);
  assign mem_read_out  = in_mem && ((opcode_q == OP_LD) || (opcode_q == OP_ADD) ||
                                    (opcode_q == OP_SUB));

  assign A_out         = acc_q;
  assign B_out         = b_q;
  assign operation_out = op_sub_q;

  assign acc_out  = acc_q;
  assign zero_out = (acc_q == '0);
  assign neg_out  = acc_q[10];
  assign busy_out = (state_q != IDLE);
  assign done_out = (state_q == DONE);

endmodule
